// File: rtl/quad_encoder_pos.sv
// Quadrature encoder to clamped 12-bit position: 2-FF sync, per-channel debounce, decoder, detent accumulator.
// Latency: pin edge -> pos/step = 2 + DEBOUNCE_CYCLES + 1 cycles; stable level change -> step = 1 cycle.
// Backpressure: none; free-running, outputs are one-cycle pulses. Define ENC_WRAP_EN to wrap instead of clamp.
module quad_encoder_pos #(
   parameter int         DEBOUNCE_CYCLES  = 25000,
   parameter int         STEPS_PER_DETENT = 4,
   parameter int         STEP_SIZE        = 8,
   parameter int         POS_MIN          = 0,
   parameter int         POS_MAX          = 639,
   parameter int         POS_INIT         = 320,
   parameter logic [1:0] IDLE_AB          = 2'b11
) (
   input  logic        clk25,
   input  logic        rst_n,
   input  logic        enc_a,
   input  logic        enc_b,
   output logic [11:0] pos,
   output logic        step_up,
   output logic        step_dn,
   output logic        enc_err
);

   localparam int               CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic signed [4:0] STEPS_S = 5'(STEPS_PER_DETENT);
   localparam logic [12:0]      STEP13   = 13'(STEP_SIZE);
   localparam logic [12:0]      MIN13    = 13'(POS_MIN);
   localparam logic [12:0]      MAX13    = 13'(POS_MAX);
   localparam logic [11:0]      MIN12    = 12'(POS_MIN);
   localparam logic [11:0]      MAX12    = 12'(POS_MAX);
   localparam logic [11:0]      INIT12   = 12'(POS_INIT);

   // Bit 1 is channel A, bit 0 is channel B throughout.
   logic [1:0]          sync1, sync2, stab, prev;
   logic [CW-1:0]       cnt [2];
   logic signed [4:0]   acc, acc_nx, acc_inc, acc_dec;
   logic                up_nx, dn_nx, err_nx;
   logic [1:0]          delta;
   logic [12:0]         up_sum;
   logic [11:0]         pos_up, pos_dn;

   // Map gray level to its position in the CW cycle 00->01->11->10.
   function automatic logic [1:0] gidx(input logic [1:0] g);
      return {g[1], g[1] ^ g[0]};
   endfunction

   // Two-flop synchronizer, nothing between the stages.
   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         sync1 <= IDLE_AB;
         sync2 <= IDLE_AB;
      end else begin
         sync1 <= {enc_a, enc_b};
         sync2 <= sync1;
      end
   end

   // Per-channel debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing cycles.
   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         stab <= IDLE_AB;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == stab[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               stab[i] <= sync2[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // Decode the sub-step from prev/stable and resolve detent completion plus next position.
   always_comb begin
      acc_nx  = acc;
      up_nx   = 1'b0;
      dn_nx   = 1'b0;
      err_nx  = 1'b0;
      acc_inc = acc + 5'sd1;
      acc_dec = acc - 5'sd1;
      delta   = gidx(stab) - gidx(prev);
      case (delta)
         2'd1: begin
            if (acc_inc == STEPS_S) begin
               up_nx  = 1'b1;
               acc_nx = '0;
            end else begin
               acc_nx = acc_inc;
            end
         end
         2'd3: begin
            if (acc_dec == -STEPS_S) begin
               dn_nx  = 1'b1;
               acc_nx = '0;
            end else begin
               acc_nx = acc_dec;
            end
         end
         2'd2: begin
            // Both channels moved at once: direction unknown, drop the partial detent.
            err_nx = 1'b1;
            acc_nx = '0;
         end
         default: acc_nx = acc;
      endcase

      up_sum = {1'b0, pos} + STEP13;
`ifdef ENC_WRAP_EN
      pos_up = (up_sum > MAX13) ? MIN12 : up_sum[11:0];
      pos_dn = ({1'b0, pos} < MIN13 + STEP13) ? MAX12 : pos - STEP13[11:0];
`else
      pos_up = (up_sum > MAX13) ? MAX12 : up_sum[11:0];
      pos_dn = ({1'b0, pos} < MIN13 + STEP13) ? MIN12 : pos - STEP13[11:0];
`endif
   end

   // Register accumulator, pulses and position; the step pulse and pos update share a cycle.
   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         prev    <= IDLE_AB;
         acc     <= '0;
         pos     <= INIT12;
         step_up <= 1'b0;
         step_dn <= 1'b0;
         enc_err <= 1'b0;
      end else begin
         prev    <= stab;
         acc     <= acc_nx;
         step_up <= up_nx;
         step_dn <= dn_nx;
         enc_err <= err_nx;
         if (up_nx)      pos <= pos_up;
         else if (dn_nx) pos <= pos_dn;
      end
   end

endmodule

// File: tb/tb_quad_encoder_pos.sv
module tb_quad_encoder_pos;

   localparam int DB = 4;

   logic        clk25 = 1'b0;
   logic        rst_n = 1'b0;
   logic        enc_a = 1'b1;
   logic        enc_b = 1'b1;
   logic [11:0] pos0, pos1;
   logic        up0, dn0, err0, up1, dn1, err1;

   int total = 0;
   int bad   = 0;

   // Reference model state: accepted level, sub-step count, positions of both instances.
   logic [1:0] lvl;
   int         acc_m;
   int         p0, p1;
   logic [1:0] cw_order [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

   always #20 clk25 = ~clk25;

   quad_encoder_pos #(.DEBOUNCE_CYCLES(DB)) dut0 (
      .clk25(clk25), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
      .pos(pos0), .step_up(up0), .step_dn(dn0), .enc_err(err0));

   quad_encoder_pos #(.DEBOUNCE_CYCLES(DB), .POS_INIT(632)) dut1 (
      .clk25(clk25), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
      .pos(pos1), .step_up(up1), .step_dn(dn1), .enc_err(err1));

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int cw_pos(input logic [1:0] g);
      for (int i = 0; i < 4; i++) if (cw_order[i] == g) return i;
      return 0;
   endfunction

   function automatic int move(input int p, input bit up);
`ifdef ENC_WRAP_EN
      if (up) return (p + 8 > 639) ? 0 : p + 8;
      return (p < 8) ? 639 : p - 8;
`else
      if (up) return (p + 8 > 639) ? 639 : p + 8;
      return (p < 8) ? 0 : p - 8;
`endif
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      {enc_a, enc_b} = 2'b11;
      repeat (3) @(posedge clk25);
      #1;
      check("rst_pos0", int'(pos0), 320);
      check("rst_pos1", int'(pos1), 632);
      check("rst_pulses", int'({up0, dn0, err0, up1, dn1, err1}), 0);
      rst_n = 1'b1;
      lvl = 2'b11; acc_m = 0; p0 = 320; p1 = 632;
   endtask

   // Hold {A,B}=ab for 'hold' cycles and compare pulse counts, timing and position.
   task automatic seg(input logic [1:0] ab, input int hold);
      int eu = 0, ed = 0, ee = 0, nu = 0, nd = 0, ne = 0, first = -1, both = 0, d;
      if (hold >= DB && ab != lvl) begin
         d = (cw_pos(ab) - cw_pos(lvl) + 4) % 4;
         if (d == 2) begin
            ee = 1; acc_m = 0;
         end else begin
            acc_m += (d == 1) ? 1 : -1;
            if (acc_m == 4) begin
               eu = 1; acc_m = 0; p0 = move(p0, 1'b1); p1 = move(p1, 1'b1);
            end else if (acc_m == -4) begin
               ed = 1; acc_m = 0; p0 = move(p0, 1'b0); p1 = move(p1, 1'b0);
            end
         end
         lvl = ab;
      end
      {enc_a, enc_b} = ab;
      for (int k = 1; k <= hold; k++) begin
         @(posedge clk25);
         #1;
         nu += int'(up0) + int'(up1);
         nd += int'(dn0) + int'(dn1);
         ne += int'(err0) + int'(err1);
         if ((up0 && dn0) || (up1 && dn1)) both++;
         if ((up0 || dn0) && first < 0) first = k;
      end
      check("step_up_cnt", nu, 2 * eu);
      check("step_dn_cnt", nd, 2 * ed);
      check("enc_err_cnt", ne, 2 * ee);
      check("up_dn_overlap", both, 0);
      check("pos0", int'(pos0), p0);
      check("pos1", int'(pos1), p1);
      if (eu + ed > 0) check("step_latency", first, 2 + DB + 1);
   endtask

   task automatic detent(input bit cw);
      for (int i = 0; i < 4; i++)
         seg(cw_order[(cw_pos(lvl) + (cw ? 1 : 3)) % 4], 10);
   endtask

   task automatic glitch();
      logic [1:0] base;
      base = lvl;
      seg(base ^ ($urandom_range(0, 1) ? 2'b10 : 2'b01), $urandom_range(1, DB - 1));
      seg(base, 10);
   endtask

   initial begin
      int dir;
      do_reset();
      // Two CW detents (second instance hits the top clamp), then one CCW.
      detent(1'b1);
      detent(1'b1);
      detent(1'b0);
      // Short A glitch must not propagate.
      seg(2'b01, 3);
      seg(2'b11, 10);
      // Double-edge jump raises an error, then a full CW detent from 00.
      seg(2'b00, 10);
      detent(1'b1);
      // Partial detent discarded by reset, then a clean detent.
      seg(cw_order[(cw_pos(lvl) + 1) % 4], 10);
      seg(cw_order[(cw_pos(lvl) + 1) % 4], 10);
      do_reset();
      detent(1'b1);
      // Run to the bottom clamp/wrap.
      for (int i = 0; i < 45; i++) detent(1'b0);
      // Randomized walk: direction bias changes every 20 segments.
      dir = 1;
      for (int i = 0; i < 300; i++) begin
         int r;
         if (i % 20 == 0) dir = $urandom_range(0, 1);
         r = $urandom_range(0, 9);
         if (r < 2) glitch();
         else if (r == 2) seg(cw_order[$urandom_range(0, 3)], $urandom_range(8, 12));
         else if (r < 8) seg(cw_order[(cw_pos(lvl) + (dir ? 1 : 3)) % 4], $urandom_range(8, 12));
         else seg(cw_order[(cw_pos(lvl) + (dir ? 3 : 1)) % 4], $urandom_range(8, 12));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
